// File: rtl/mips_cpu_muldiv_if.sv
// Purpose: bundle of the multiply/divide unit's request, direct-write and result signals.
// Latency: none, wiring only.
// Backpressure: the master must hold off new requests while busy is high; extra starts are dropped.
interface mips_cpu_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             abort;
   logic             wr_hi;
   logic             wr_lo;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             divzero;

   // execute-stage control side
   modport master (
      output start, op, a, b, abort, wr_hi, wr_lo, wdata,
      input  busy, done, hi, lo, divzero
   );

   // multiply/divide unit side
   modport slave (
      input  start, op, a, b, abort, wr_hi, wr_lo, wdata,
      output busy, done, hi, lo, divzero
   );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU into private HI/LO, plus MTHI/MTLO direct writes.
// Latency: WIDTH+2 cycles start-to-done (2 cycles for divide by zero with MULDIV_DIVZERO_EN).
// Backpressure: busy high while an op is in flight; start and direct writes are ignored then.
// Optional feature macro: MULDIV_DIVZERO_EN (divide by zero short-cut and divzero flag).
module mips_cpu_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNTW  = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   mips_cpu_muldiv_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t               state, state_nx;
   logic [CNTW-1:0]      cnt;
   logic                 is_div;     // latched op class
   logic                 neg_res;    // product / quotient needs negation
   logic                 neg_rem;    // remainder takes dividend's sign
   logic                 dz_pend;    // current op is a short-cut divide by zero
   logic [WIDTH-1:0]     addend;     // multiplicand magnitude or divisor magnitude
   logic [2*WIDTH-1:0]   acc;        // product accumulator; low half is quotient/dividend for divide
   logic [WIDTH:0]       rem;        // partial remainder
   logic [WIDTH-1:0]     hi_q, lo_q;
   logic                 done_q, divzero_q;

   logic                 go, dz_req;
   logic                 sa, sb;
   logic [WIDTH-1:0]     abs_a, abs_b;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_sh;
   logic [WIDTH+1:0]     div_diff;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quo, rmd;

   // an abort in the same cycle as start swallows the start
   assign go = (state == IDLE) && bus.start && !bus.abort;

`ifdef MULDIV_DIVZERO_EN
   assign dz_req = bus.op[1] && (bus.b == '0);
`else
   assign dz_req = 1'b0;
`endif

   // op[0] clear means signed; take magnitudes (most-negative maps to itself, read as unsigned)
   assign sa    = !bus.op[0] && bus.a[WIDTH-1];
   assign sb    = !bus.op[0] && bus.b[WIDTH-1];
   assign abs_a = sa ? -bus.a : bus.a;
   assign abs_b = sb ? -bus.b : bus.b;

   // one shift-add step: add multiplicand into the upper half when the current multiplier bit is set
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? addend : {WIDTH{1'b0}})};

   // one restoring-divide step: shift next dividend bit in and trial-subtract the divisor
   assign div_sh   = {rem[WIDTH-1:0], acc[WIDTH-1]};
   assign div_diff = {1'b0, div_sh} - {2'b00, addend};

   // sign correction applied at FIX
   assign prod = neg_res ? -acc : acc;
   assign quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rmd  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next-state: IDLE -> RUN (or straight to FIX for a short-cut divide by zero) -> FIX -> IDLE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (go) state_nx = dz_req ? FIX : RUN;
         RUN: begin
            if (bus.abort)             state_nx = IDLE;
            else if (cnt == CNTW'(1))  state_nx = FIX;
         end
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // datapath: operand capture, iteration, result write-back and direct HI/LO writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         is_div    <= 1'b0;
         neg_res   <= 1'b0;
         neg_rem   <= 1'b0;
         dz_pend   <= 1'b0;
         addend    <= '0;
         acc       <= '0;
         rem       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         done_q <= (state == FIX) && !bus.abort;
         case (state)
            IDLE: begin
               if (go) begin
                  cnt     <= CNTW'(WIDTH);
                  is_div  <= bus.op[1];
                  neg_res <= sa ^ sb;
                  neg_rem <= bus.op[1] && sa;
                  dz_pend <= dz_req;
                  rem     <= '0;
                  if (bus.op[1]) begin
                     addend <= abs_b;
                     // short-cut divide by zero returns the raw dividend in HI
                     acc    <= {{WIDTH{1'b0}}, (dz_req ? bus.a : abs_a)};
                  end else begin
                     addend <= abs_a;
                     acc    <= {{WIDTH{1'b0}}, abs_b};
                  end
               end else if (!bus.start) begin
                  if (bus.wr_hi) hi_q <= bus.wdata;
                  if (bus.wr_lo) lo_q <= bus.wdata;
               end
            end
            RUN: begin
               cnt <= cnt - CNTW'(1);
               if (is_div) begin
                  rem               <= div_diff[WIDTH+1] ? div_sh : div_diff[WIDTH:0];
                  acc[WIDTH-1:0]    <= {acc[WIDTH-2:0], ~div_diff[WIDTH+1]};
               end else begin
                  acc <= {mul_sum, acc[WIDTH-1:1]};
               end
            end
            FIX: begin
               if (!bus.abort) begin
                  divzero_q <= dz_pend;
                  if (dz_pend) begin
                     hi_q <= acc[WIDTH-1:0];
                     lo_q <= {WIDTH{1'b1}};
                  end else if (is_div) begin
                     hi_q <= rmd;
                     lo_q <= quo;
                  end else begin
                     hi_q <= prod[2*WIDTH-1:WIDTH];
                     lo_q <= prod[WIDTH-1:0];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy    = (state != IDLE);
   assign bus.done    = done_q;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.divzero = divzero_q;

endmodule
